// File: rtl/xnn_pkg.sv
// Shared definitions for the XOR neuron test sequencer and its companion network.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
//
// Contents:
//   xnn_state_t  - sequencer FSM state encoding (IDLE, SETTLE, DONE)
//   XOR_TRUTH    - golden XOR truth table, bit i = y for pattern i (x1x2 = i)
//   FX_ONE       - Q4.4 fixed-point representation of 1.0 used by the network
//   NUM_PATTERNS - number of input patterns in one sweep
//   fx_from_bool - encodes a boolean drive as a Q4.4 value for the network
//   sat_inc8     - 8-bit saturating increment
package xnn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } xnn_state_t;

    localparam logic [3:0] XOR_TRUTH    = 4'b0110;
    localparam int         FX_ONE       = 16;
    localparam int         NUM_PATTERNS = 4;

    // Boolean sequencer drive mapped onto the network's Q4.4 input scale.
    function automatic logic [7:0] fx_from_bool(input logic b);
        return b ? 8'(FX_ONE) : 8'd0;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/xor_pattern_sequencer.sv
// Sweeps the four boolean patterns through an external neuron network and grades the truth table.
// Latency: start seen in cycle 0 gives done in cycle 4*SETTLE_CYCLES+1; back-to-back sweeps repeat every 4*SETTLE_CYCLES+2.
// Backpressure: none; start is only sampled in IDLE, abort only while busy, rst overrides both.
//
// Parameters:
//   SETTLE_CYCLES - cycles each pattern is held before y_in is sampled (1..255)
//   EXPECTED      - golden truth table, bit i = required y for pattern i
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   sweep request (IDLE only)
//   abort        in   sweep cancel (SETTLE only)
//   x1, x2       out  pattern drive to the network, x1 = idx[1], x2 = idx[0]
//   y_in         in   step output returned by the network
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse on sweep completion
//   truth_table  out  result of the last completed sweep
//   pass         out  truth_table == EXPECTED, valid from done onward
//   err_count    out  saturating count of failed sweeps (only with XOR_SEQ_ERRCNT_EN)
// Build option: define XOR_SEQ_ERRCNT_EN to add the err_count output and its counter.
module xor_pattern_sequencer
    import xnn_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECTED      = XOR_TRUTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       x1,
    output logic       x2,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth_table,
`ifdef XOR_SEQ_ERRCNT_EN
    output logic [7:0] err_count,
`endif
    output logic       pass
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    xnn_state_t    state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    shadow_q, shadow_d;
    logic [3:0]    tt_q, tt_d;
    logic          pass_q, pass_d;
    logic          sweep_end;

    // Next-state and datapath. The truth table and pass flag are loaded on the
    // edge that enters DONE, using the shadow value that already includes the
    // final capture, so both are valid in the same cycle done is high.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        tt_d      = tt_q;
        pass_d    = pass_q;
        sweep_end = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETTLE;
                    idx_d    = 2'd0;
                    cnt_d    = '0;
                    shadow_d = 4'b0000;
                end
            end

            SETTLE: begin
                // abort takes precedence over a capture in the same cycle
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    shadow_d[idx_q] = y_in;
                    cnt_d           = '0;
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                    end else begin
                        state_d   = DONE;
                        sweep_end = 1'b1;
                        tt_d      = shadow_d;
                        pass_d    = (shadow_d == EXPECTED);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end

            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= '0;
            shadow_q <= 4'b0000;
            tt_q     <= 4'b0000;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            tt_q     <= tt_d;
            pass_q   <= pass_d;
        end
    end

`ifdef XOR_SEQ_ERRCNT_EN
    logic [7:0] err_q;

    // Bumped together with the truth-table load so the new count is visible with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 8'd0;
        end else if (sweep_end && (shadow_d != EXPECTED)) begin
            err_q <= sat_inc8(err_q);
        end
    end

    assign err_count = err_q;
`endif

    // All outputs decode straight from registers; nothing combinational from inputs.
    assign x1          = (state_q == SETTLE) & idx_q[1];
    assign x2          = (state_q == SETTLE) & idx_q[0];
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign truth_table = tt_q;
    assign pass        = pass_q;

endmodule

// File: tb/tb_xor_pattern_sequencer.sv
// Self-checking bench for xor_pattern_sequencer with a scoreboard on done.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_xor_pattern_sequencer;

    typedef struct {
        int         cyc;
        logic [3:0] tt;
        logic       pass;
    } exp_t;

    logic clk;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    exp_t qa[$];
    exp_t qb[$];

    // Instance A: SETTLE_CYCLES=2, XOR network
    logic       rst_a, start_a, abort_a, x1_a, x2_a, y_a, busy_a, done_a, pass_a;
    logic [3:0] tt_a;
    // Instance B: SETTLE_CYCLES=1, selectable network
    logic       rst_b, start_b, abort_b, x1_b, x2_b, y_b, busy_b, done_b, pass_b;
    logic [3:0] tt_b;
    logic [1:0] ymode_b;
`ifdef XOR_SEQ_ERRCNT_EN
    logic [7:0] err_a, err_b;
`endif

    assign y_a = x1_a ^ x2_a;
    assign y_b = (ymode_b == 2'd0) ? (x1_b ^ x2_b) : (ymode_b == 2'd1);

    xor_pattern_sequencer #(.SETTLE_CYCLES(2), .EXPECTED(4'b0110)) u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .abort(abort_a),
        .x1(x1_a), .x2(x2_a), .y_in(y_a), .busy(busy_a), .done(done_a),
        .truth_table(tt_a),
`ifdef XOR_SEQ_ERRCNT_EN
        .err_count(err_a),
`endif
        .pass(pass_a)
    );

    xor_pattern_sequencer #(.SETTLE_CYCLES(1), .EXPECTED(4'b0110)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .abort(abort_b),
        .x1(x1_b), .x2(x2_b), .y_in(y_b), .busy(busy_b), .done(done_b),
        .truth_table(tt_b),
`ifdef XOR_SEQ_ERRCNT_EN
        .err_count(err_b),
`endif
        .pass(pass_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_a(input int c, input logic [3:0] tt, input logic p);
        exp_t e;
        e.cyc = c; e.tt = tt; e.pass = p;
        qa.push_back(e);
    endtask

    task automatic push_b(input int c, input logic [3:0] tt, input logic p);
        exp_t e;
        e.cyc = c; e.tt = tt; e.pass = p;
        qb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitors: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done_a) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_done_cycle", cyc, e.cyc);
                chk("a_truth_table", int'(tt_a), int'(e.tt));
                chk("a_pass", int'(pass_a), int'(e.pass));
            end
        end
    end

    always @(negedge clk) begin
        if (done_b) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_done_cycle", cyc, e.cyc);
                chk("b_truth_table", int'(tt_b), int'(e.tt));
                chk("b_pass", int'(pass_b), int'(e.pass));
            end
        end
    end

    initial begin
        int t0;
        rst_a = 1'b1; start_a = 1'b0; abort_a = 1'b0;
        rst_b = 1'b1; start_b = 1'b0; abort_b = 1'b0; ymode_b = 2'd0;
        step(3);
        rst_a = 1'b0; rst_b = 1'b0;
        step(1);

        // Reset state
        chk("rst_x1", int'(x1_a), 0);
        chk("rst_x2", int'(x2_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_truth_table", int'(tt_a), 0);
        chk("rst_pass", int'(pass_a), 0);

        // Abort at cycle 4: idle at cycle 5, no done, results untouched
        start_a = 1'b1; t0 = cyc; step(1); start_a = 1'b0;
        step(3);
        abort_a = 1'b1; step(1); abort_a = 1'b0;
        chk("abort4_cycle", cyc - t0, 5);
        chk("abort4_busy", int'(busy_a), 0);
        chk("abort4_truth_table", int'(tt_a), 0);
        chk("abort4_pass", int'(pass_a), 0);
        step(12);

        // Abort on a capture cycle (cycle 2) wins over the capture
        start_a = 1'b1; step(1); start_a = 1'b0;
        step(1);
        abort_a = 1'b1; step(1); abort_a = 1'b0;
        chk("abort_cap_busy", int'(busy_a), 0);
        chk("abort_cap_x", int'({x1_a, x2_a}), 0);
        step(12);

        // Full XOR sweep; abort asserted alongside start in IDLE is ignored
        start_a = 1'b1; abort_a = 1'b1; t0 = cyc;
        push_a(t0 + 9, 4'b0110, 1'b1);
        step(1);
        start_a = 1'b0; abort_a = 1'b0;
        chk("sweep_busy_c1", int'(busy_a), 1);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("sweep_x1x2_c%0d", i), int'({x1_a, x2_a}), (i - 1) / 2);
            step(1);
        end
        chk("sweep_x_in_done", int'({x1_a, x2_a}), 0);
        step(1);
        chk("sweep_idle_busy", int'(busy_a), 0);
        chk("sweep_hold_truth_table", int'(tt_a), 6);
        step(8);

        // Start pulsed mid-sweep is ignored
        start_a = 1'b1; t0 = cyc;
        push_a(t0 + 9, 4'b0110, 1'b1);
        step(1); start_a = 1'b0;
        step(2);
        start_a = 1'b1; step(1); start_a = 1'b0;
        step(14);

        // Reset at cycle 6 discards the sweep and clears everything
        start_a = 1'b1; t0 = cyc; step(1); start_a = 1'b0;
        step(5);
        rst_a = 1'b1; step(1); rst_a = 1'b0;
        chk("rst_mid_cycle", cyc - t0, 7);
        chk("rst_mid_x", int'({x1_a, x2_a}), 0);
        chk("rst_mid_busy", int'(busy_a), 0);
        chk("rst_mid_done", int'(done_a), 0);
        chk("rst_mid_truth_table", int'(tt_a), 0);
        chk("rst_mid_pass", int'(pass_a), 0);
        step(2);
        start_a = 1'b1; t0 = cyc;
        push_a(t0 + 9, 4'b0110, 1'b1);
        step(1); start_a = 1'b0;
        step(14);

        // SETTLE_CYCLES=1, y tied high: done at cycle 5, all ones, fails
        ymode_b = 2'd1;
        start_b = 1'b1; t0 = cyc;
        push_b(t0 + 5, 4'b1111, 1'b0);
        step(1); start_b = 1'b0;
        step(8);
`ifdef XOR_SEQ_ERRCNT_EN
        chk("b_err_after_ones", int'(err_b), 1);
`endif

        // SETTLE_CYCLES=1 with XOR: one pattern per cycle
        ymode_b = 2'd0;
        start_b = 1'b1; t0 = cyc;
        push_b(t0 + 5, 4'b0110, 1'b1);
        step(1); start_b = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("b_x1x2_c%0d", i), int'({x1_b, x2_b}), i - 1);
            step(1);
        end
        step(6);
`ifdef XOR_SEQ_ERRCNT_EN
        chk("b_err_after_pass", int'(err_b), 1);
`endif

        // 256 back-to-back failing sweeps with start held high
        rst_b = 1'b1; step(1); rst_b = 1'b0;
        ymode_b = 2'd2;
        start_b = 1'b1; t0 = cyc;
        for (int k = 0; k < 256; k++) push_b(t0 + 5 + 6 * k, 4'b0000, 1'b0);
        step(1531);
        start_b = 1'b0;
        step(16);
`ifdef XOR_SEQ_ERRCNT_EN
        chk("b_err_saturated", int'(err_b), 255);
`endif
        chk("b_final_busy", int'(busy_b), 0);

        chk("a_missing_dones", qa.size(), 0);
        chk("b_missing_dones", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
